// File: rtl/direct_mapped_cache_pkg.sv
// Shared geometry constants and cache-line record for the direct-mapped cache.
// The top's default parameters are taken from here, so geometry changes belong in this package.
package direct_mapped_cache_pkg;

    localparam int CACHE_LINES = 16;
    localparam int MEM_DEPTH   = 1024;
    localparam int OFFSET_W    = 2;
    localparam int IDX_W       = $clog2(CACHE_LINES);
    localparam int TAG_W       = 32 - IDX_W - OFFSET_W;
    localparam int MEM_AW      = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cache_line_t;

endpackage

// File: rtl/direct_mapped_cache_main_memory_model.sv
// Word-addressed backing memory: combinational read, synchronous write.
// Contents are stored XOR-ed with their own address, so an all-zero power-up state reads back as word w = w.
module main_memory_model #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_reg [MEM_WORDS];
    logic [31:0] addr_ext;

    assign addr_ext = 32'(addr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata ^ addr_ext;
        end
    end

    assign rdata = mem_reg[addr] ^ addr_ext;

endmodule

// File: rtl/direct_mapped_cache.sv
// Single-cycle direct-mapped, write-through, write-allocate cache with integrated backing memory
// and running access/miss counters.
module direct_mapped_cache
    import direct_mapped_cache_pkg::*;
#(
    parameter int NUM_LINES = CACHE_LINES,
    parameter int MEM_WORDS = MEM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        access,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    input  logic        Write_Enable,
    output logic [31:0] Data_Out,
    output logic        Hit_Miss,
    output logic [31:0] total_accesses,
    output logic [31:0] total_misses
);

    localparam int AW = $clog2(MEM_WORDS);

    cache_line_t      lines_reg [NUM_LINES];
    cache_line_t      cur_line;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             mem_we;
    logic [31:0]      mem_rdata;
    logic [31:0]      fill_data;
    logic [31:0]      result_next;
    logic             unused_offset;

    assign index         = Address[IDX_W+OFFSET_W-1:OFFSET_W];
    assign tag           = Address[31:IDX_W+OFFSET_W];
    assign unused_offset = ^Address[OFFSET_W-1:0];

    assign cur_line = lines_reg[index];
    assign hit      = cur_line.valid && (cur_line.tag == tag);

    // Reset wins over a concurrent access, so the memory write is suppressed too.
    assign mem_we = access && Write_Enable && !reset;

    main_memory_model #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (Address[AW+OFFSET_W-1:OFFSET_W]),
        .wdata (Write_Data),
        .rdata (mem_rdata)
    );

    assign fill_data = Write_Enable ? Write_Data : mem_rdata;

    always_comb begin
        result_next = fill_data;
        if (!Write_Enable && hit) begin
            result_next = cur_line.data;
        end
    end

    // Only valid bits are reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_reg[i].valid <= 1'b0;
            end
        end else if (access) begin
            lines_reg[index] <= '{valid: 1'b1, tag: tag, data: fill_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Data_Out       <= '0;
            Hit_Miss       <= 1'b0;
            total_accesses <= '0;
            total_misses   <= '0;
        end else if (access) begin
            Data_Out       <= result_next;
            Hit_Miss       <= hit;
            total_accesses <= total_accesses + 32'd1;
            if (!hit) begin
                total_misses <= total_misses + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed plus randomized bench for direct_mapped_cache against an address-level reference model.
module tb_direct_mapped_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        access = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_Data = '0;
    logic        Write_Enable = 1'b0;
    logic [31:0] Data_Out;
    logic        Hit_Miss;
    logic [31:0] total_accesses;
    logic [31:0] total_misses;

    always #5 clk = ~clk;

    direct_mapped_cache dut (
        .clk            (clk),
        .reset          (reset),
        .access         (access),
        .Address        (Address),
        .Write_Data     (Write_Data),
        .Write_Enable   (Write_Enable),
        .Data_Out       (Data_Out),
        .Hit_Miss       (Hit_Miss),
        .total_accesses (total_accesses),
        .total_misses   (total_misses)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: memory as a plain array, each line remembers the full word address it holds.
    logic [31:0] m_mem   [1024];
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_acc   = '0;
    logic [31:0] m_miss  = '0;
    logic [31:0] m_out   = '0;
    logic        m_hit   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"},     Data_Out,         m_out);
        check({tag, ".hit"},      {31'd0, Hit_Miss}, {31'd0, m_hit});
        check({tag, ".accesses"}, total_accesses,   m_acc);
        check({tag, ".misses"},   total_misses,     m_miss);
    endtask

    task automatic do_access(input logic [31:0] addr, input bit we, input logic [31:0] wd);
        logic [29:0] word;
        int          idx;
        int          mi;
        bit          hit;
        @(negedge clk);
        access       = 1'b1;
        Address      = addr;
        Write_Enable = we;
        Write_Data   = wd;
        word = addr[31:2];
        idx  = int'(word % 30'd16);
        mi   = int'(word % 30'd1024);
        hit  = m_valid[idx] && (m_word[idx] == word);
        m_acc = m_acc + 1;
        if (!hit) m_miss = m_miss + 1;
        m_hit = hit;
        if (we) begin
            m_mem[mi] = wd;
            m_out     = wd;
        end else if (hit) begin
            m_out = m_data[idx];
        end else begin
            m_out = m_mem[mi];
        end
        m_valid[idx] = 1'b1;
        m_word[idx]  = word;
        m_data[idx]  = m_out;
        @(posedge clk);
        #1;
        access = 1'b0;
        $display("access %0d: addr=%h we=%0d wd=%h -> out=%h hit=%0d misses=%0d",
                 m_acc, addr, we, wd, Data_Out, Hit_Miss, total_misses);
        check_outputs("access");
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_acc  = '0;
        m_miss = '0;
        m_out  = '0;
        m_hit  = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] addr;
        for (int w = 0; w < 1024; w++) m_mem[w] = 32'(w);
        model_reset();

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        $display("reset released: out=%h hit=%0d acc=%0d miss=%0d", Data_Out, Hit_Miss, total_accesses, total_misses);
        check_outputs("reset");

        // Directed sequence from the plan
        do_access(32'd12,  1'b0, '0);
        do_access(32'd12,  1'b0, '0);
        do_access(32'd20,  1'b0, '0);
        do_access(32'd60,  1'b1, 32'hBBBBBBBB);
        do_access(32'd60,  1'b0, '0);
        do_access(32'd256, 1'b1, 32'h0ABABABA);
        check("plan.misses_after_6", total_misses, 32'd4);

        // Conflicts on index 0 and write-through visibility after eviction
        do_access(32'd0,  1'b0, '0);
        do_access(32'd64, 1'b0, '0);
        do_access(32'd0,  1'b0, '0);
        do_access(32'd64, 1'b1, 32'h00001234);
        do_access(32'd0,  1'b0, '0);
        do_access(32'd64, 1'b0, '0);
        check("conflict.wt_data", Data_Out, 32'h00001234);

        // Idle cycles leave everything unchanged
        repeat (5) @(negedge clk);
        $display("idle 5 cycles: out=%h hit=%0d acc=%0d miss=%0d", Data_Out, Hit_Miss, total_accesses, total_misses);
        check_outputs("idle");

        // Asynchronous reset between edges, with a pending write that must be discarded
        @(negedge clk);
        access       = 1'b1;
        Address      = 32'd12;
        Write_Enable = 1'b1;
        Write_Data   = 32'hDEADBEEF;
        #2 reset = 1'b1;
        #1;
        model_reset();
        $display("async reset: out=%h hit=%0d acc=%0d miss=%0d", Data_Out, Hit_Miss, total_accesses, total_misses);
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        access       = 1'b0;
        Write_Enable = 1'b0;
        check_outputs("reset_over_access");
        @(negedge clk);
        reset = 1'b0;

        do_access(32'd12, 1'b0, '0);
        check("reread12.data", Data_Out, 32'h00000003);

        // Randomized traffic over a small address window plus occasional high-bit aliases
        for (int n = 0; n < 300; n++) begin
            word = 32'($urandom_range(0, 95));
            if ($urandom_range(0, 7) == 0) word = word | 32'h2000_0000;
            addr = {word[29:0], 2'($urandom_range(0, 3))};
            do_access(addr, ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
